// File: rtl/trivium_stream.sv
// trivium_stream: Trivium keystream engine producing WIDTH keystream bits per clock.
// Handles key/IV load, the 1152-round warm-up and a valid/ready output handshake.
// Optional feature: define TRIVIUM_STREAM_CNT_EN to add the 32-bit accepted-word
// counter on port word_cnt. Without the macro the port and counter are absent.
module trivium_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [79:0]      key,
  input  logic [79:0]      iv,
  output logic             busy,
  output logic [WIDTH-1:0] ks_data,
  output logic             ks_valid,
  input  logic             ks_ready
`ifdef TRIVIUM_STREAM_CNT_EN
  ,
  output logic [31:0]      word_cnt
`endif
);

  // Number of advances needed to cover the 1152 warm-up rounds.
  localparam int N     = 1152 / WIDTH;
  localparam int CNT_W = $clog2(N);

  // Only widths that divide 1152 and stay within the 66-round feedback
  // distance are legal; anything else is rejected at elaboration.
  if (!(WIDTH == 1 || WIDTH == 2 || WIDTH == 4 || WIDTH == 8 ||
        WIDTH == 16 || WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
    $error("trivium_stream: illegal WIDTH %0d", WIDTH);
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [287:0]       s_q, s_d;    // s_q[i-1] holds Trivium bit s(i)
  logic [287:0]       s_adv;       // state after WIDTH rounds
  logic [WIDTH-1:0]   z_adv;       // keystream of those WIDTH rounds
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  // Initial state image for a key/IV pair; the three ones sit at s286..s288.
  function automatic logic [287:0] load_state(input logic [79:0] k,
                                              input logic [79:0] v);
    logic [287:0] st;
    st          = '0;
    st[79:0]    = k;
    st[172:93]  = v;
    st[287:285] = 3'b111;
    return st;
  endfunction

  // WIDTH unrolled Trivium rounds applied to the current state; z of round j lands in bit j.
  always_comb begin
    logic [287:0] s;
    logic         t1, t2, t3;
    s     = s_q;
    t1    = 1'b0;
    t2    = 1'b0;
    t3    = 1'b0;
    z_adv = '0;
    for (int j = 0; j < WIDTH; j++) begin
      t1       = s[65] ^ s[92];
      t2       = s[161] ^ s[176];
      t3       = s[242] ^ s[287];
      z_adv[j] = t1 ^ t2 ^ t3;
      t1       = t1 ^ (s[90] & s[91]) ^ s[170];
      t2       = t2 ^ (s[174] & s[175]) ^ s[263];
      t3       = t3 ^ (s[285] & s[286]) ^ s[68];
      s        = {s[286:177], t2, s[175:93], t1, s[91:0], t3};
    end
    s_adv = s;
  end

  // The word on offer is derived from the current state, so it holds while stalled.
  assign ks_data = z_adv;

  // Next-state and output decode; a load overrides whatever the FSM would do.
  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    ks_valid = 1'b0;
    case (state_q)
      IDLE: begin
      end
      INIT: begin
        busy = 1'b1;
        s_d  = s_adv;
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RUN: begin
        ks_valid = 1'b1;
        if (ks_ready) begin
          s_d = s_adv;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (load) begin
      state_d = INIT;
      s_d     = load_state(key, iv);
      cnt_d   = CNT_W'(N - 1);
    end
  end

  // State register, warm-up counter and cipher state; reset yields the all-zero state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef TRIVIUM_STREAM_CNT_EN
  logic        accept;
  logic [31:0] wcnt_q;

  // A handshake colliding with a load is not an accepted word.
  assign accept = ks_valid && ks_ready && !load;

  // Accepted-word counter, cleared by reset and load, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= '0;
    end else if (load) begin
      wcnt_q <= '0;
    end else if (accept) begin
      wcnt_q <= wcnt_q + 32'd1;
    end
  end

  assign word_cnt = wcnt_q;
`endif

endmodule

// File: tb/tb_trivium_stream.sv
// Testbench for trivium_stream: seven instances (WIDTH 1..64) share load/key/iv,
// each with its own ready. Expected keystream comes from a bit-serial model.
module tb_trivium_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [79:0] key;
  logic [79:0] iv;
  logic [6:0]  rdy;
  logic [6:0]  vld;
  logic [6:0]  bsy;
  logic [63:0] ksd [7];
`ifdef TRIVIUM_STREAM_CNT_EN
  logic [31:0] wcnt [7];
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 7; g++) begin : g_dut
    localparam int W = 1 << g;
    logic [W-1:0] d;
    trivium_stream #(.WIDTH(W)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .key      (key),
      .iv       (iv),
      .busy     (bsy[g]),
      .ks_data  (d),
      .ks_valid (vld[g]),
      .ks_ready (rdy[g])
`ifdef TRIVIUM_STREAM_CNT_EN
      ,
      .word_cnt (wcnt[g])
`endif
    );
    assign ksd[g] = 64'(d);
  end

  // Bit-serial reference: state s[1..288] and the keystream bits after warm-up.
  bit ms [1:288];
  bit ref_q [$];

  task automatic m_stream(input logic [79:0] k, input logic [79:0] v, input int nbits);
    bit t1, t2, t3, z;
    for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      ms[i]      = k[i-1];
      ms[93 + i] = v[i-1];
    end
    ms[286] = 1'b1; ms[287] = 1'b1; ms[288] = 1'b1;
    ref_q.delete();
    for (int r = 0; r < 1152 + nbits; r++) begin
      t1 = ms[66] ^ ms[93];
      t2 = ms[162] ^ ms[177];
      t3 = ms[243] ^ ms[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
      t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
      t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
      for (int i = 93; i > 1; i--) ms[i] = ms[i-1];
      ms[1] = t3;
      for (int i = 177; i > 94; i--) ms[i] = ms[i-1];
      ms[94] = t1;
      for (int i = 288; i > 178; i--) ms[i] = ms[i-1];
      ms[178] = t2;
      if (r >= 1152) ref_q.push_back(z);
    end
  endtask

  function automatic logic [63:0] exp_word(input int base, input int w);
    logic [63:0] r;
    r = '0;
    for (int j = 0; j < w; j++) r[j] = ref_q[base + j];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives load for exactly one rising edge; returns at the negedge after it.
  task automatic load_pulse(input logic [79:0] k, input logic [79:0] v);
    load = 1'b1;
    key  = k;
    iv   = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Called at the negedge right after the load edge; busy must last N cycles.
  task automatic warm_check(input int g);
    int n, k, bc;
    n  = 1152 >> g;
    k  = 0;
    bc = 0;
    while (!vld[g] && k < n + 10) begin
      if (bsy[g]) bc++;
      @(negedge clk);
      k++;
    end
    chk($sformatf("warm_len_w%0d", 1 << g), 64'(k), 64'(n));
    chk($sformatf("busy_cycles_w%0d", 1 << g), 64'(bc), 64'(n));
    chk($sformatf("busy_low_in_run_w%0d", 1 << g), 64'(bsy[g]), 64'd0);
  endtask

  // All widths take 64 words with ready held high from the load onwards.
  task automatic golden(input logic [79:0] k);
    int  cnt [7] = '{default: 0};
    int  cyc;
    bit  done;
    m_stream(k, 80'd0, 4096);
    rdy = '1;
    load_pulse(k, 80'd0);
    cyc = 0;
    while (cyc < 1400) begin
      done = 1'b1;
      for (int g = 0; g < 7; g++) begin
        if (cnt[g] < 64) begin
          done = 1'b0;
          if (vld[g]) begin
            chk($sformatf("golden_w%0d_word%0d", 1 << g, cnt[g]), ksd[g],
                exp_word(cnt[g] * (1 << g), 1 << g));
            cnt[g]++;
          end
        end
      end
      if (done) break;
      @(negedge clk);
      cyc++;
    end
    rdy = '0;
    for (int g = 0; g < 7; g++) chk($sformatf("golden_done_w%0d", 1 << g), 64'(cnt[g]), 64'd64);
  endtask

  // WIDTH=8 instance consumes nwords with ready high pct% of cycles.
  task automatic stream_g3(input int nwords, input int pct);
    int          n, cyc;
    bit          r, stalled;
    logic [63:0] prev;
    n = 0; cyc = 0; stalled = 1'b0; prev = '0;
    while (n < nwords && cyc < nwords * 30 + 200) begin
      r      = ($urandom_range(0, 99) < pct);
      rdy[3] = r;
      if (vld[3]) begin
        if (stalled) chk("stall_hold", ksd[3], prev);
        if (r) begin
          chk($sformatf("stream_word%0d", n), ksd[3], exp_word(n * 8, 8));
          n++;
        end
        stalled = !r;
        prev    = ksd[3];
      end else begin
        stalled = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    rdy[3] = 1'b0;
    chk("stream_done", 64'(n), 64'(nwords));
  endtask

  task automatic chk_cnt(input string tag, input int exp);
`ifdef TRIVIUM_STREAM_CNT_EN
    chk(tag, 64'(wcnt[3]), 64'(exp));
`endif
  endtask

  initial begin
    logic [79:0] ka, kb, va, vb;
    ka = 80'({$urandom, $urandom, $urandom});
    kb = 80'({$urandom, $urandom, $urandom});
    va = 80'({$urandom, $urandom, $urandom});
    vb = 80'({$urandom, $urandom, $urandom});
    rst_n = 1'b0; load = 1'b0; key = '0; iv = '0; rdy = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 7; g++) begin
      chk("reset_valid", 64'(vld[g]), 64'd0);
      chk("reset_busy", 64'(bsy[g]), 64'd0);
      chk("reset_data", ksd[g], 64'd0);
    end
    chk_cnt("reset_word_cnt", 0);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_valid", 64'(vld[3]), 64'd0);
      chk("idle_busy", 64'(bsy[3]), 64'd0);
    end

    // Warm-up length for every width.
    for (int g = 0; g < 7; g++) begin
      load_pulse(80'd0, 80'd0);
      warm_check(g);
    end

    // Golden streams across all widths.
    golden(80'd0);
    golden(80'h8000_0000_0000_0000_0000);

    // Backpressure over 1000 words.
    m_stream(ka, va, 8000);
    load_pulse(ka, va);
    warm_check(3);
    stream_g3(1000, 40);
    chk_cnt("bp_word_cnt", 1000);

    // Reload during warm-up.
    load_pulse(ka, va);
    repeat (49) @(negedge clk);
    load_pulse(kb, vb);
    chk("init_reload_busy", 64'(bsy[3]), 64'd1);
    warm_check(3);
    m_stream(kb, vb, 160);
    stream_g3(20, 100);
    chk_cnt("init_reload_cnt", 20);

    // Reload in RUN after 10 words, ready low on the load edge.
    m_stream(ka, va, 80);
    load_pulse(ka, va);
    warm_check(3);
    stream_g3(10, 100);
    load_pulse(kb, vb);
    chk("run_reload_valid", 64'(vld[3]), 64'd0);
    chk("run_reload_busy", 64'(bsy[3]), 64'd1);
    chk_cnt("run_reload_cnt0", 0);
    warm_check(3);
    m_stream(kb, vb, 80);
    stream_g3(10, 100);
    chk_cnt("run_reload_cnt", 10);

    // Load colliding with an accepting handshake.
    m_stream(ka, va, 40);
    load_pulse(ka, va);
    warm_check(3);
    stream_g3(5, 100);
    rdy[3] = 1'b1;
    load_pulse(kb, vb);
    chk("collide_valid", 64'(vld[3]), 64'd0);
    chk("collide_busy", 64'(bsy[3]), 64'd1);
    chk_cnt("collide_cnt0", 0);
    warm_check(3);
    m_stream(kb, vb, 80);
    stream_g3(10, 60);
    chk_cnt("collide_cnt", 10);

    // Asynchronous reset while in RUN.
    chk("pre_reset_valid", 64'(vld[3]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 7; g++) begin
      chk("async_reset_valid", 64'(vld[g]), 64'd0);
      chk("async_reset_busy", 64'(bsy[g]), 64'd0);
      chk("async_reset_data", ksd[g], 64'd0);
    end
    chk_cnt("async_reset_cnt", 0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy   = '1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("post_reset_valid", 64'(vld[3]), 64'd0);
      chk("post_reset_busy", 64'(bsy[3]), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trivium_stream.md
# trivium_stream

Parametrised Trivium keystream engine that produces `WIDTH` keystream bits per clock instead of one. Runs a key/IV load, the 1152-round warm-up and a valid/ready output handshake, so it can sit directly between the UART/FIFO datapath and the XOR stage without an external enable/full gating loop. It is the successor of the bit-serial `trivium` core in the top-level design.

## Interface

**Parameters**
- `WIDTH`, default 8: keystream bits per output word and Trivium rounds per advance. Legal values are 1, 2, 4, 8, 16, 32 and 64 (all divide 1152 and are ≤ 66). Any other value is an elaboration error.

**Ports** (one clock; reset is asynchronous and active-low)
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `load`, input, 1: single-cycle request to load `key`/`iv` and restart.
- `key`, input, 80: `key[i]` is Trivium K(i+1). Sampled only on a `load` edge.
- `iv`, input, 80: `iv[i]` is IV(i+1). Sampled only on a `load` edge.
- `busy`, output, 1: high while warm-up is in progress.
- `ks_data`, output, WIDTH: keystream word. `ks_data[0]` is the earliest bit.
- `ks_valid`, output, 1: `ks_data` holds a valid word.
- `ks_ready`, input, 1: the consumer accepts the word.
- `word_cnt`, output, 32: accepted-word count. Present only when `TRIVIUM_STREAM_CNT_EN` is defined.

## Operation

**State register `s[1..288]`.** One Trivium round:
- t1 = s66^s93; t2 = s162^s177; t3 = s243^s288; z = t1^t2^t3
- t1 ^= (s91&s92)^s171; t2 ^= (s175&s176)^s264; t3 ^= (s286&s287)^s69
- s1..93 ← (t3, s1..92); s94..177 ← (t1, s94..176); s178..288 ← (t2, s178..287)

One advance applies WIDTH rounds combinationally. `ks_data[j]` is the z of round j within that advance.

**Load.** On a `load` edge the state is set to:
- s1..80 = K, s81..93 = 0
- s94..173 = IV, s174..177 = 0
- s178..285 = 0, s286..288 = 1

**FSM** (states IDLE, INIT, RUN):
- IDLE: `ks_valid` = 0, `busy` = 0, state unchanged. `load` → INIT.
- INIT: `busy` = 1. Advances once every cycle, z discarded. A down-counter starts at N−1, where N = 1152/WIDTH. When the counter reaches 0 and the final advance completes → RUN.
- RUN: `ks_valid` = 1. The state advances only on a cycle where `ks_valid && ks_ready`. `ks_data` is a combinational function of the current state, so it stays stable while stalled.

**Boundary conditions**
- `load` in any state, including INIT or RUN, aborts the current activity. It reloads the state, restarts the counter and enters INIT.
- `load` has priority over a simultaneous handshake. That handshake is not counted and does not advance the state.
- `load` held high for several cycles reloads on every cycle; warm-up starts at the last one.
- `ks_ready` is ignored outside RUN.
- Asynchronous reset: all 288 state bits = 0, FSM = IDLE, counter = 0, `busy` = 0, `ks_valid` = 0, `ks_data` = 0 (all-zero state gives z = 0), `word_cnt` = 0. Reset mid-INIT or mid-RUN returns to IDLE with no output.

## Timing

- With `load` sampled at edge T, `busy` is high from T+1 through T+N, and `ks_valid` is first high after edge T+N.
- WIDTH=8 gives N=144; WIDTH=1 gives N=1152; WIDTH=64 gives N=18.
- In RUN with `ks_ready` held high, a new word is delivered every cycle (throughput WIDTH bits/clk).
- Handshake latency is zero: the next word appears after the accepting edge.
- A `load` at edge L drops `ks_valid` and raises `busy` after L.

## Configuration

- `TRIVIUM_STREAM_CNT_EN` defined: adds `word_cnt`.
  - It increments by 1 on every accepted handshake and wraps from 0xFFFFFFFF to 0.
  - It is cleared by reset and by `load`.
- `TRIVIUM_STREAM_CNT_EN` undefined: the `word_cnt` port and its counter are absent. All other behaviour is identical.

## Test plan

- **Reset values:** assert `rst_n`=0 mid-RUN → `ks_valid`=0, `busy`=0, `ks_data`=0 and `word_cnt`=0 immediately. After release, stays IDLE with no `load`.
- **Warm-up length:** WIDTH=8, key=0, iv=0, `load` at edge T → `busy` is high for exactly 144 cycles and `ks_valid` rises after edge T+144. Repeat with WIDTH=1 (1152) and WIDTH=64 (18).
- **Golden compare:** key=0x0…0 and 0x80…0, iv=0, `ks_ready`=1. Take 64 words and compare them bit-for-bit against a bit-serial model of the round equations, for every legal WIDTH. The concatenated streams must be identical across widths.
- **Backpressure:** `ks_ready` toggled randomly, 40% high, over 1000 words → `ks_data` is stable while stalled, with no word dropped or duplicated versus the model. `word_cnt`=1000.
- **Reload:** `load` mid-INIT (cycle 50) and mid-RUN (after 10 words) with a new key → warm-up restarts, a full N cycles of `busy` follow, and the stream matches the new-key model. `word_cnt` returns to 0.
- **Load/handshake collision:** `load` and `ks_ready` high on the same edge in RUN → the handshake is not counted and the subsequent stream equals a fresh load.
